fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the program ROM. Generates the ROM read address every cycle, absorbs the ROM's one-cycle registered read latency, and presents fetched words with their PCs to the core through a valid/ready handshake backed by a 2-entry buffer. Also accepts a jump redirect that flushes in-flight and buffered words.

## Interface
- WORD_SIZE, 20, width of ROM words, addresses and PCs
- RESET_PC, 0, first address fetched after reset

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rom_addr_o  out  WORD_SIZE  ROM read address; ROM returns data for it on rom_value_i one cycle later
- rom_value_i  in  WORD_SIZE  registered ROM read data
- jump_i  in  1  redirect fetch to jump_target_i this cycle
- jump_target_i  in  WORD_SIZE  redirect address
- instr_o  out  WORD_SIZE  instruction word at buffer head
- instr_pc_o  out  WORD_SIZE  address instr_o was fetched from
- instr_valid_o  out  1  buffer head holds a valid word
- instr_ready_i  in  1  consumer accepts head this cycle

## Operation
- State: fetch_pc; inflight bit + inflight_pc (address issued last cycle); 2-entry FIFO of {pc, word}; occupancy 0..2.
- rom_addr_o = jump_i ? jump_target_i : fetch_pc (combinational). ROM has no enable; addresses not issued are read and ignored.
- pop = instr_valid_o & instr_ready_i.
- issue = jump_i | (occupancy + inflight - pop < 2). Credit rule guarantees every in-flight word has a free slot.
- On issue without jump: fetch_pc <= fetch_pc + 1, inflight <= 1, inflight_pc <= fetch_pc. No issue: fetch_pc holds, inflight <= 0.
- Each cycle with inflight=1 (and no jump): {inflight_pc, rom_value_i} pushed into FIFO tail.
- Jump: FIFO emptied, current in-flight word discarded, inflight <= 1, inflight_pc <= jump_target_i, fetch_pc <= jump_target_i + 1. A pop coinciding with a jump counts as completed; other entries are discarded.
- PC arithmetic modulo 2^WORD_SIZE; 0xFFFFF + 1 wraps to 0x00000.
- Simultaneous push and pop: occupancy unchanged, order preserved; pop on occupancy 2 exposes second entry next cycle.
- instr_o/instr_pc_o undefined-but-stable when instr_valid_o=0; must hold constant while valid=1 and ready=0.

## Timing
- Reset (async, immediate): fetch_pc=RESET_PC, inflight=0, occupancy=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, rom_addr_o=RESET_PC.
- Cycle 0 after reset release: RESET_PC issued. Cycle 1: data on rom_value_i, pushed. Cycle 2: instr_valid_o=1.
- Fetch-to-valid latency 2 cycles; redirect (jump cycle N) to first target word valid: cycle N+2.
- Sustained throughput 1 word/cycle with instr_ready_i held high.
- Full backpressure: at most 2 buffered words, no issue, fetch_pc frozen at next unissued address; resumes with no gaps or duplicates.
- Combinational paths: jump_i/jump_target_i -> rom_addr_o only; instr_ready_i affects state only (no comb path to outputs).
- Reset asserted mid-operation: all state cleared in same cycle; pending and buffered words lost.

## Test plan
- ROM word[i]=0x10000+i, release reset -> valid low cycles 0-1; cycles 2,3,4 present pc 0,1,2 with 0x10000,0x10001,0x10002, ready high throughout.
- Ready low cycles 4-8 -> instr_o held at pc 2, occupancy reaches 2, rom issue stops; ready high -> pcs 2,3,4,5 in order, one per cycle, none skipped.
- jump_i with target 0x100 at cycle 10, ready high -> no pre-jump word valid after cycle 10; cycle 12 presents pc 0x100 value 0x10100, then 0x101.
- Ready low, FIFO full, jump to 0x040 -> flush; two cycles later head is pc 0x040; ready still low holds it stable.
- Jump to 0xFFFFF -> pcs 0xFFFFF then 0x00000 presented consecutively.
- Assert reset asynchronously between edges while valid=1 -> instr_valid_o drops immediately; after release, pc RESET_PC valid 2 cycles later.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues ROM addresses, absorbs the one-cycle ROM latency and
// buffers up to two fetched {pc, word} pairs behind a valid/ready handshake.
module fetch_unit #(
    parameter int                   WORD_SIZE = 20,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [WORD_SIZE-1:0] rom_addr_o,
    input  logic [WORD_SIZE-1:0] rom_value_i,
    input  logic                 jump_i,
    input  logic [WORD_SIZE-1:0] jump_target_i,
    output logic [WORD_SIZE-1:0] instr_o,
    output logic [WORD_SIZE-1:0] instr_pc_o,
    output logic                 instr_valid_o,
    input  logic                 instr_ready_i
);

    logic [WORD_SIZE-1:0] r_fetch_pc;
    logic                 r_inflight;
    logic [WORD_SIZE-1:0] r_inflight_pc;
    logic [WORD_SIZE-1:0] r_pc0, r_word0;
    logic [WORD_SIZE-1:0] r_pc1, r_word1;
    logic [1:0]           r_count;

    logic                 w_pop;
    logic                 w_push;
    logic                 w_issue;
    logic [2:0]           w_credit;

    assign w_pop  = (r_count != 2'd0) & instr_ready_i;
    assign w_push = r_inflight & ~jump_i;

    // Slots still committed after this cycle; never issue unless a free slot remains.
    assign w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue  = jump_i | (w_credit < 3'd2);

    assign rom_addr_o    = jump_i ? jump_target_i : r_fetch_pc;
    assign instr_valid_o = (r_count != 2'd0);
    assign instr_o       = r_word0;
    assign instr_pc_o    = r_pc0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_pc0         <= '0;
            r_word0       <= '0;
            r_pc1         <= '0;
            r_word1       <= '0;
            r_count       <= 2'd0;
        end else begin
            if (jump_i) begin
                r_fetch_pc    <= jump_target_i + 1'b1;
                r_inflight    <= 1'b1;
                r_inflight_pc <= jump_target_i;
            end else if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + 1'b1;
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
            end else begin
                r_inflight    <= 1'b0;
            end

            // Head register only moves when a second entry exists, so it stays stable when empty.
            if (jump_i) begin
                r_count <= 2'd0;
            end else begin
                case ({w_push, w_pop})
                    2'b10: begin
                        if (r_count == 2'd0) begin
                            r_pc0   <= r_inflight_pc;
                            r_word0 <= rom_value_i;
                        end else begin
                            r_pc1   <= r_inflight_pc;
                            r_word1 <= rom_value_i;
                        end
                        r_count <= r_count + 2'd1;
                    end
                    2'b01: begin
                        if (r_count == 2'd2) begin
                            r_pc0   <= r_pc1;
                            r_word0 <= r_word1;
                        end
                        r_count <= r_count - 2'd1;
                    end
                    2'b11: begin
                        if (r_count == 2'd2) begin
                            r_pc0   <= r_pc1;
                            r_word0 <= r_word1;
                            r_pc1   <= r_inflight_pc;
                            r_word1 <= rom_value_i;
                        end else begin
                            r_pc0   <= r_inflight_pc;
                            r_word0 <= rom_value_i;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random ready/jump traffic checked against
// an in-order delivered-PC stream model and a registered ROM model.
module tb_fetch_unit;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] rom_addr_o;
    logic [W-1:0] rom_value_i;
    logic         jump_i = 1'b0;
    logic [W-1:0] jump_target_i = '0;
    logic [W-1:0] instr_o;
    logic [W-1:0] instr_pc_o;
    logic         instr_valid_o;
    logic         instr_ready_i = 1'b0;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_pc = '0;
    int           quiet = 0;

    fetch_unit #(.WORD_SIZE(W), .RESET_PC('0)) dut (
        .clk           (clk),
        .reset         (reset),
        .rom_addr_o    (rom_addr_o),
        .rom_value_i   (rom_value_i),
        .jump_i        (jump_i),
        .jump_target_i (jump_target_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rom_fn(input logic [W-1:0] a);
        logic [W-1:0] r;
        r = 20'h10000 + a;
        return r;
    endfunction

    always @(posedge clk) rom_value_i <= rom_fn(rom_addr_o);

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1ns later, update the model at the rising edge.
    task automatic cyc(input logic rdy, input logic jmp, input logic [W-1:0] tgt, input int ev);
        logic v;
        instr_ready_i = rdy;
        jump_i        = jmp;
        jump_target_i = tgt;
        #1;
        v = instr_valid_o;
        if (ev >= 0) check("valid", W'(v), (ev == 1) ? 20'd1 : 20'd0);
        if (v) begin
            check("head_pc", instr_pc_o, exp_pc);
            check("head_word", instr_o, rom_fn(exp_pc));
        end
        if (quiet >= 2) check("live_valid", W'(v), 20'd1);
        if (jmp) check("jump_addr", rom_addr_o, tgt);
        @(posedge clk);
        if (v && rdy) exp_pc = exp_pc + 1'b1;
        if (jmp) exp_pc = tgt;
        quiet = (rdy && !jmp) ? quiet + 1 : 0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", W'(instr_valid_o), 20'd0);
        check("rst_instr", instr_o, 20'd0);
        check("rst_pc", instr_pc_o, 20'd0);
        check("rst_addr", rom_addr_o, 20'd0);
        @(negedge clk);
        reset = 1'b0;

        // Startup latency and streaming
        cyc(1'b1, 1'b0, '0, 0);
        cyc(1'b1, 1'b0, '0, 0);
        cyc(1'b1, 1'b0, '0, 1);
        cyc(1'b1, 1'b0, '0, 1);

        // Backpressure: head holds pc 2, fetch freezes at address 4
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, '0, 1);
            check("frozen_addr", rom_addr_o, 20'd4);
        end
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, '0, 1);

        // Jump with ready high
        cyc(1'b1, 1'b1, 20'h00100, 1);
        cyc(1'b1, 1'b0, '0, 0);
        cyc(1'b1, 1'b0, '0, 1);
        cyc(1'b1, 1'b0, '0, 1);

        // Jump while buffer is full and ready low
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1);
        cyc(1'b0, 1'b1, 20'h00040, 1);
        cyc(1'b0, 1'b0, '0, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1);

        // PC wrap
        cyc(1'b1, 1'b1, 20'hFFFFF, 1);
        cyc(1'b1, 1'b0, '0, 0);
        cyc(1'b1, 1'b0, '0, 1);
        cyc(1'b1, 1'b0, '0, 1);
        cyc(1'b1, 1'b0, '0, 1);

        // Asynchronous reset between edges while valid
        instr_ready_i = 1'b1;
        jump_i        = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", W'(instr_valid_o), 20'd0);
        check("async_instr", instr_o, 20'd0);
        check("async_pc", instr_pc_o, 20'd0);
        check("async_addr", rom_addr_o, 20'd0);
        @(negedge clk);
        reset  = 1'b0;
        exp_pc = '0;
        quiet  = 0;
        cyc(1'b1, 1'b0, '0, 0);
        cyc(1'b1, 1'b0, '0, 0);
        cyc(1'b1, 1'b0, '0, 1);
        cyc(1'b1, 1'b0, '0, 1);

        // Random ready / jump traffic
        for (int i = 0; i < 400; i++) begin
            logic         r;
            logic         j;
            logic [W-1:0] t;
            r = ($urandom_range(0, 9) < 7);
            j = ($urandom_range(0, 19) == 0);
            t = W'($urandom);
            cyc(r, j, t, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
